// File: rtl/psum_bank_ctrl.sv
// Initiator-side controller for an 8-lane psum SRAM bank: overwrite or read-modify-write accumulate
// of incoming psum vectors, plus valid/ready readout of an address range with optional per-lane ReLU.
module psum_bank_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 32,
    parameter int addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [addr_bw-1:0]     in_addr,
    input  logic [col*psum_bw-1:0] in_data,
    input  logic                   in_first,
    input  logic                   dump_start,
    input  logic [addr_bw-1:0]     dump_base,
    input  logic [addr_bw:0]       dump_len,
    input  logic                   dump_relu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   dump_done,
    output logic                   busy,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_bw-1:0]     sram_a,
    output logic [col*psum_bw-1:0] sram_d,
    input  logic [col*psum_bw-1:0] sram_q
);
    localparam int DW = col * psum_bw;
    localparam logic [addr_bw:0] MAX_LEN = {1'b1, {addr_bw{1'b0}}};
    localparam logic [addr_bw:0] ONE     = {{addr_bw{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACC_RD, ACC_WR, DUMP} state_t;

    state_t             state_q, state_d;
    logic [addr_bw-1:0] acc_addr_q, acc_addr_d, ptr_q, ptr_d, a_q, a_d;
    logic [DW-1:0]      acc_data_q, acc_data_d, out_data_q, out_data_d, d_q, d_d;
    logic [addr_bw:0]   iss_left_q, iss_left_d, acc_left_q, acc_left_d;
    logic               relu_q, relu_d, dump_rd_q, dump_rd_d, q_vld_q, q_vld_d;
    logic               out_valid_q, out_valid_d, dump_done_q, dump_done_d;
    logic               cen_q, cen_d, wen_q, wen_d;
    logic [DW-1:0]      acc_sum, relu_data;
    logic               in_hs, accept, issue;
    logic [addr_bw:0]   len_eff;

    always_comb begin
        acc_sum   = '0;
        relu_data = '0;
        for (int unsigned i = 0; i < col; i++) begin
            acc_sum[i*psum_bw +: psum_bw] = sram_q[i*psum_bw +: psum_bw] + acc_data_q[i*psum_bw +: psum_bw];
            relu_data[i*psum_bw +: psum_bw] = (relu_q && sram_q[i*psum_bw + psum_bw - 1])
                                            ? '0 : sram_q[i*psum_bw +: psum_bw];
        end
    end

    // A dump read stays in flight from issue until its data lands in out_data, so at most one word is
    // ever outstanding and a stalled output can never be overrun.
    always_comb begin
        in_ready = (state_q == IDLE) && !reset;
        in_hs    = in_valid && in_ready;
        accept   = out_valid_q && out_ready;
        len_eff  = (dump_len == '0) ? MAX_LEN : dump_len;
        issue    = (state_q == DUMP) && !dump_rd_q && !q_vld_q && (iss_left_q != '0)
                   && (!out_valid_q || out_ready);

        state_d     = state_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        ptr_d       = ptr_q;
        iss_left_d  = iss_left_q;
        acc_left_d  = acc_left_q;
        relu_d      = relu_q;
        dump_rd_d   = 1'b0;
        q_vld_d     = dump_rd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        dump_done_d = 1'b0;
        cen_d       = 1'b1;
        wen_d       = 1'b1;
        a_d         = a_q;
        d_d         = d_q;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    cen_d = 1'b0;
                    a_d   = in_addr;
                    if (in_first) begin
                        wen_d = 1'b0;
                        d_d   = in_data;
                    end else begin
                        acc_addr_d = in_addr;
                        acc_data_d = in_data;
                        state_d    = ACC_RD;
                    end
                end else if (dump_start) begin
                    ptr_d      = dump_base;
                    iss_left_d = len_eff;
                    acc_left_d = len_eff;
                    relu_d     = dump_relu;
                    state_d    = DUMP;
                end
            end
            ACC_RD: state_d = ACC_WR;
            ACC_WR: begin
                cen_d   = 1'b0;
                wen_d   = 1'b0;
                a_d     = acc_addr_q;
                d_d     = acc_sum;
                state_d = IDLE;
            end
            DUMP: begin
                if (issue) begin
                    cen_d      = 1'b0;
                    a_d        = ptr_q;
                    ptr_d      = ptr_q + 1'b1;
                    iss_left_d = iss_left_q - 1'b1;
                    dump_rd_d  = 1'b1;
                end
                if (q_vld_q) begin
                    out_data_d  = relu_data;
                    out_valid_d = 1'b1;
                end
                if (accept) begin
                    out_valid_d = 1'b0;
                    acc_left_d  = acc_left_q - 1'b1;
                    if (acc_left_q == ONE) begin
                        dump_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_addr_q  <= '0;
            acc_data_q  <= '0;
            ptr_q       <= '0;
            iss_left_q  <= '0;
            acc_left_q  <= '0;
            relu_q      <= 1'b0;
            dump_rd_q   <= 1'b0;
            q_vld_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            dump_done_q <= 1'b0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
            ptr_q       <= ptr_d;
            iss_left_q  <= iss_left_d;
            acc_left_q  <= acc_left_d;
            relu_q      <= relu_d;
            dump_rd_q   <= dump_rd_d;
            q_vld_q     <= q_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dump_done_q <= dump_done_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            d_q         <= d_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dump_done = dump_done_q;
    assign sram_cen  = cen_q;
    assign sram_wen  = wen_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;
endmodule
